// File: rtl/sram_like_resp.sv
// sram_like_resp: SRAM-like bus responder in front of a single-cycle synchronous SRAM.
// Optional feature macro RAND_DELAY_EN adds LFSR-driven accept gating and response jitter.
module sram_like_resp #(
  parameter int OUTSTANDING = 2,
  parameter int RESP_DELAY  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int            PW        = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [2:0]    OUT_MAX   = 3'(OUTSTANDING);
  localparam logic [PW-1:0] LAST_SLOT = PW'(OUTSTANDING - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  logic [2:0]             outst;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [OUTSTANDING-1:0] buf_valid;
  logic [31:0]            buf_data [OUTSTANDING];
  logic [2:0]             buf_cnt  [OUTSTANDING];
  logic                   cap_pending;
  logic                   cap_is_write;
  logic [31:0]            cap_data;
  logic [2:0]             cap_cnt;
  logic                   rand_gate;
  logic                   accept;
  logic                   head_ready;
  logic                   bypass;
  logic                   unused_size;

  // Transfer size never affects byte enables; wstrb alone decides them.
  assign unused_size = ^size;

`ifdef RAND_DELAY_EN
  logic [15:0] lfsr;
  logic [3:0]  cnt_sum;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'h00A5;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign rand_gate = lfsr[0];
  assign cnt_sum   = 4'(RESP_DELAY) + {2'b00, lfsr[3:2]};
  assign cap_cnt   = cnt_sum[3] ? 3'd7 : cnt_sum[2:0];
`else
  assign rand_gate = 1'b1;
  assign cap_cnt   = 3'(RESP_DELAY);
`endif

  // The capture cycle counts as the first delay cycle; a zero-delay capture that
  // is also the oldest transaction is returned straight from the SRAM output.
  assign cap_data   = cap_is_write ? 32'h0 : ram_rdata;
  assign head_ready = buf_valid[rd_ptr] && (buf_cnt[rd_ptr] == 3'd0);
  assign bypass     = cap_pending && !buf_valid[rd_ptr] && (cap_cnt == 3'd0);

  assign data_ok = !reset && (head_ready || bypass);
  assign rdata   = !data_ok ? 32'h0 : (head_ready ? buf_data[rd_ptr] : cap_data);
  assign addr_ok = !reset && rand_gate && ((outst < OUT_MAX) || data_ok);
  assign accept  = req && addr_ok;

  assign ram_en    = accept;
  assign ram_wen   = (accept && wr) ? wstrb : 4'b0000;
  assign ram_addr  = addr;
  assign ram_wdata = wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid    <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      outst        <= 3'd0;
      cap_pending  <= 1'b0;
      cap_is_write <= 1'b0;
    end else begin
      cap_pending  <= accept;
      cap_is_write <= wr;

      if (head_ready) begin
        buf_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= ptr_inc(rd_ptr);
      end

      if (cap_pending) begin
        if (bypass) begin
          rd_ptr <= ptr_inc(rd_ptr);
          wr_ptr <= ptr_inc(wr_ptr);
        end else begin
          buf_valid[wr_ptr] <= 1'b1;
          wr_ptr            <= ptr_inc(wr_ptr);
        end
      end

      if (accept && !data_ok)      outst <= outst + 3'd1;
      else if (!accept && data_ok) outst <= outst - 3'd1;
    end
  end

  // NOTE: payload storage is deliberately not reset; buf_valid alone decides
  // whether an entry means anything, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (buf_valid[i] && (buf_cnt[i] != 3'd0)) buf_cnt[i] <= buf_cnt[i] - 3'd1;
    end
    if (cap_pending && !bypass) begin
      buf_data[wr_ptr] <= cap_data;
      buf_cnt[wr_ptr]  <= (cap_cnt == 3'd0) ? 3'd0 : cap_cnt - 3'd1;
    end
  end

endmodule

// File: doc/sram_like_resp.md
# sram_like_resp

Responder end of the SRAM-like bus (req/wr/size/wstrb/addr/wdata, addr_ok/data_ok/rdata) driven by the pipeline fetch and memory stages. It sits between one SRAM-like master and a single-cycle synchronous SRAM. It accepts requests subject to an outstanding-transaction limit and issues each one to the SRAM in the accept cycle. It buffers the results and returns `data_ok` strictly in request order after a programmable response delay. It serves as the inst/data port model for the SoC-lite bench and as the adapter for on-chip RAM.

## Interface
Parameters:
- OUTSTANDING, 2: maximum accepted-but-not-returned transactions (1..4).
- RESP_DELAY, 0: extra cycles between SRAM read-data capture and earliest `data_ok` (0..7).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  master request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  transfer size (0 = byte, 1 = half, 2 = word); ignored for write-enable generation, `wstrb` governs
- wstrb  in  4  byte write strobes (used only when `wr`=1)
- addr  in  32  byte address
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle when `req` is also high
- data_ok  out  1  one response returned this cycle
- rdata  out  32  read data, valid only while `data_ok`=1 for a read
- ram_en  out  1  SRAM enable
- ram_wen  out  4  SRAM byte write enables
- ram_addr  out  32  SRAM address (`addr` passed through unchanged)
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data, valid the cycle after `ram_en`

## Operation
- `outst`: count of accepted transactions not yet returned by `data_ok`. It is 0..OUTSTANDING and 3 bits wide.
- `addr_ok` = !reset && (outst < OUTSTANDING || data_ok). A slot freed by `data_ok` is reusable in the same cycle. `addr_ok` may be high without `req`.
- Accept (req && addr_ok) in cycle T drives, combinationally in T:
  - `ram_en`=1
  - `ram_wen` = wr ? wstrb : 4'b0
  - `ram_addr`/`ram_wdata` = addr/wdata
- When no request is accepted, `ram_en`=0 and `ram_wen`=0.
- Capture stage: in T+1 the block writes an entry into the circular response buffer (OUTSTANDING entries). Each entry holds {is_write, data, cnt}:
  - data = ram_rdata for reads, 0 for writes.
  - cnt = RESP_DELAY.
- Every valid entry with cnt ≠ 0 decrements cnt by 1 each cycle.
- `data_ok` = head valid && head cnt == 0.
  - `rdata` = head data; 0 when `data_ok`=0.
  - The head pops the same cycle and its read pointer advances (wraps modulo OUTSTANDING).
- At most one `data_ok` per cycle; responses are strictly in acceptance order.
- `outst` update: +1 on accept, −1 on `data_ok`, unchanged when both occur.
- Simultaneous capture into the last free slot and pop of the head in the same cycle is legal.
- There is no backpressure on responses: the master must take `data_ok` in the cycle it is asserted.

## Timing
- Reset values: all buffer entries invalid, pointers 0, `outst`=0, `data_ok`=0, `rdata`=0, `ram_en`=0, `ram_wen`=0.
- `addr_ok` is 0 during reset and 1 in the first cycle after reset.
- Latency: accept at T gives earliest `data_ok` at T+1+RESP_DELAY. With RESP_DELAY=0, `data_ok` arrives in T+1, with `rdata`=ram_rdata registered through the buffer bypass.
- Throughput: with OUTSTANDING ≥ RESP_DELAY+1 (and ≥2 when RESP_DELAY=0 is not bypassed), back-to-back accepts sustain one transaction per cycle.
- Full: at outst == OUTSTANDING with no `data_ok` that cycle, `addr_ok`=0. A request held by the master is accepted in the cycle of the next `data_ok`.
- Reset mid-operation:
  - In-flight entries are discarded and no `data_ok` is issued for them afterwards.
  - An SRAM write issued in the reset cycle is suppressed (`ram_en`=0).

## Configuration
- RAND_DELAY_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'h00A5 on reset) advances every cycle.
  - `addr_ok` is additionally gated by LFSR[0]=1.
  - Captured cnt = RESP_DELAY + LFSR[3:2] (saturating at 7).
  - Ordering and the outstanding limit are unchanged.
- Undefined: no LFSR; `addr_ok` and delays are purely deterministic as above.

## Test plan
- Reset, then a read req to addr 32'hbfc00000 with RAM word 32'h3c1d0010, RESP_DELAY=0 -> `addr_ok` in T, `ram_en`=1 with `ram_wen`=0 in T; `data_ok`=1 with `rdata`=32'h3c1d0010 in T+1.
- Write to 0x10 with wstrb=4'b0011 and wdata=32'h12345678, then read 0x10 (RAM word initially 0) -> `ram_wen`=4'b0011 on the write, `data_ok` for the write returns `rdata`=0, read returns 32'h00005678.
- OUTSTANDING=2, RESP_DELAY=3, `req` held high on 4 reads -> `addr_ok` at T and T+1, low T+2..T+3, high at T+4 together with the first `data_ok`; 4 `data_ok` in order.
- Back-to-back reads to 0x0,0x4,0x8 with RESP_DELAY=0 -> accepts in 3 consecutive cycles, `data_ok` in 3 consecutive cycles with data in address order.
- Reset asserted the cycle after accepting 2 reads -> no `data_ok` ever; `outst`=0 and `addr_ok`=1 in the first cycle after reset.
- RAND_DELAY_EN, 100 random read/write mixes against a reference memory -> every response in order, data matches, never more than OUTSTANDING outstanding.
